ula_core: RTL and testbench
===========================

Name: ula_core

Overview:
- 16-bit arithmetic/logic unit for the processor datapath. It combines accumulator operand A with register operand Ry under a 3-bit operation select.
- Result and status flags are registered: one-cycle latency, single clock domain.
- Feeds the bus/register-file write-back path. Op 100 drives A onto the bus ("out").

Parameters:
- WIDTH, 16, operand/result width in bits. Bit index 0 is the MSB (big-endian vector range [0:WIDTH-1]).

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op valid this cycle
- A  input  WIDTH  operand A (accumulator)
- Ry  input  WIDTH  operand Ry (register operand)
- OpSelect  input  3  operation code
- result  output  WIDTH  registered result
- out_valid  output  1  result/flags valid, asserted one cycle after in_valid
- zero  output  1  result == 0
- negative  output  1  result MSB (bit 0)
- carry  output  1  carry out (add) / no-borrow (sub); 0 for logic ops
- overflow  output  1  signed two's-complement overflow (add/sub); 0 otherwise

Behaviour:
- Reset: while resetn = 0, result, out_valid, zero, negative, carry and overflow are all 0, asynchronously and immediately. They stay 0 until the first clock edge with in_valid = 1 after release.
- Opcodes, combinational next value:
  - 000 ADD: A + Ry, modulo 2^WIDTH.
  - 001 SUB: A - Ry, computed as A + ~Ry + 1, modulo 2^WIDTH.
  - 010 NAND: ~(A & Ry), bitwise.
  - 011 PASS_RY: Ry.
  - 100 OUT: A (Ry ignored).
  - 101 OR: A | Ry.
  - 110 XOR: A ^ Ry.
  - 111 NOT: ~A.
- Flags:
  - carry for ADD = bit WIDTH of the (WIDTH+1)-bit sum.
  - carry for SUB = carry out of A + ~Ry + 1, i.e. 1 when A >= Ry unsigned (no borrow).
  - overflow for ADD = operands have the same sign and the result sign differs.
  - overflow for SUB = operand signs differ and the result sign differs from A.
  - carry and overflow are 0 for all non-arithmetic ops.
  - zero and negative are derived from the registered result, for every op.
- Timing:
  - On a rising edge with in_valid = 1: result and flags load the new values and out_valid <= 1.
  - On a rising edge with in_valid = 0: result and flags hold their previous values and out_valid <= 0.
  - Back-to-back in_valid is supported at full rate, one result per cycle. No backpressure.
- Latency: exactly 1 clock from sampled inputs to result/out_valid.
- Wrap-around: 0xFFFF + 0x0001 = 0x0000 with carry = 1 and zero = 1. 0x0000 - 0x0001 = 0xFFFF with carry = 0 and negative = 1.
- Reset mid-operation: an in-flight result is discarded; outputs return to 0 immediately.
- No X propagation on outputs after reset, even if OpSelect or the operands are X while in_valid = 0.

Test Plan:
- Reset: hold resetn = 0 with in_valid = 1, A = 5, Ry = 3 -> result = 0, all flags 0, out_valid = 0. Release, then one edge -> result = 8.
- ADD: A = 2, Ry = 1, op 000 -> next cycle result = 3, zero = 0, carry = 0. Also A = 0x7FFF, Ry = 1 -> result = 0x8000, overflow = 1, negative = 1.
- SUB: A = 6, Ry = 2, op 001 -> result = 4, carry = 1. Also A = 0, Ry = 1 -> result = 0xFFFF, carry = 0, negative = 1.
- NAND / logic ops: A = 1, Ry = 0, op 010 -> result = 0xFFFF. Also op 110 with A = Ry = 0x1234 -> result = 0, zero = 1.
- OUT / PASS: A = 7, op 100 -> result = 7. Also Ry = 9, op 011 -> result = 9.
- Hold and pipelining: back-to-back ops (ADD, SUB, NAND, OUT) on consecutive cycles produce results in order, each one cycle late. Deassert in_valid -> result holds the last value and out_valid = 0.

Source files
------------

// File: rtl/ula_core.sv
// 16-bit datapath ALU: combines accumulator A with register operand Ry, registering
// the result and status flags one cycle after each valid operation.
module ula_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] Ry,
  input  logic [2:0]       OpSelect,
  output logic [0:WIDTH-1] result,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned EXT_W = WIDTH + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  logic [EXT_W-1:0] sum_add;
  logic [EXT_W-1:0] sum_sub;
  logic [WIDTH-1:0] res_next;
  logic             carry_next;
  logic             ovf_next;
  logic             a_sign;
  logic             r_sign;

  // Operand bit 0 is the MSB, so it carries the sign.
  assign a_sign = A[0];
  assign r_sign = Ry[0];

  // Next result and arithmetic flags; logic ops leave carry/overflow cleared.
  always_comb begin
    sum_add    = {1'b0, A} + {1'b0, Ry};
    sum_sub    = {1'b0, A} + {1'b0, ~Ry} + EXT_W'(1);
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (OpSelect)
      OP_ADD: begin
        res_next   = sum_add[WIDTH-1:0];
        carry_next = sum_add[WIDTH];
        ovf_next   = (a_sign == r_sign) && (sum_add[WIDTH-1] != a_sign);
      end
      OP_SUB: begin
        res_next   = sum_sub[WIDTH-1:0];
        carry_next = sum_sub[WIDTH];
        ovf_next   = (a_sign != r_sign) && (sum_sub[WIDTH-1] != a_sign);
      end
      OP_NAND: res_next = ~(A & Ry);
      OP_PASS: res_next = Ry;
      OP_OUT:  res_next = A;
      OP_OR:   res_next = A | Ry;
      OP_XOR:  res_next = A ^ Ry;
      default: res_next = ~A;
    endcase
  end

  // Output register: load on in_valid, otherwise hold everything but out_valid.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      result    <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= res_next;
        zero     <= (res_next == '0);
        negative <= res_next[WIDTH-1];
        carry    <= carry_next;
        overflow <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_ula_core.sv
// Directed self-checking bench for ula_core; each observation packs
// {out_valid, zero, negative, carry, overflow, result}.
module tb_ula_core;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] ry;
  logic [2:0]  op_sel;
  logic [15:0] result;
  logic        out_valid, zero, negative, carry, overflow;
  logic [20:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  ula_core #(.WIDTH(16)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .A        (a),
    .Ry       (ry),
    .OpSelect (op_sel),
    .result   (result),
    .out_valid(out_valid),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow)
  );

  assign obs = {out_valid, zero, negative, carry, overflow, result};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic drive(input logic [2:0] op, input logic [15:0] a_v, input logic [15:0] r_v);
    @(negedge clock);
    in_valid = 1'b1;
    op_sel   = op;
    a        = a_v;
    ry       = r_v;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    in_valid = 1'b1;
    op_sel   = 3'b000;
    a        = 16'd5;
    ry       = 16'd3;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (obs !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h", obs, 21'd0);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (obs !== {5'b10000, 16'd8}) begin
      n_bad++;
      $display("FAIL reset_release: got %h want %h", obs, {5'b10000, 16'd8});
    end
  endtask

  task automatic test_add();
    logic [15:0] av[4] = '{16'h0002, 16'h7FFF, 16'hFFFF, 16'h8000};
    logic [15:0] rv[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
    logic [20:0] ex[4] = '{{5'b10000, 16'h0003}, {5'b10101, 16'h8000},
                           {5'b11010, 16'h0000}, {5'b11011, 16'h0000}};
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, av[i], rv[i]);
      @(posedge clock);
      #1;
      n_cmp++;
      if (obs !== ex[i]) begin
        n_bad++;
        $display("FAIL add[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] av[4] = '{16'h0006, 16'h0000, 16'h8000, 16'h0005};
    logic [15:0] rv[4] = '{16'h0002, 16'h0001, 16'h0001, 16'h0005};
    logic [20:0] ex[4] = '{{5'b10010, 16'h0004}, {5'b10100, 16'hFFFF},
                           {5'b10011, 16'h7FFF}, {5'b11010, 16'h0000}};
    for (int i = 0; i < 4; i++) begin
      drive(3'b001, av[i], rv[i]);
      @(posedge clock);
      #1;
      n_cmp++;
      if (obs !== ex[i]) begin
        n_bad++;
        $display("FAIL sub[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_logic();
    // First entry sets carry so the following NAND proves carry is cleared.
    logic [2:0]  opv[6] = '{3'b000, 3'b010, 3'b110, 3'b101, 3'b111, 3'b010};
    logic [15:0] av[6]  = '{16'hFFFF, 16'h0001, 16'h1234, 16'h00F0, 16'h00FF, 16'hFFFF};
    logic [15:0] rv[6]  = '{16'h0001, 16'h0000, 16'h1234, 16'h0F00, 16'hAAAA, 16'hFFFF};
    logic [20:0] ex[6]  = '{{5'b11010, 16'h0000}, {5'b10100, 16'hFFFF},
                            {5'b11000, 16'h0000}, {5'b10000, 16'h0FF0},
                            {5'b10100, 16'hFF00}, {5'b11000, 16'h0000}};
    for (int i = 0; i < 6; i++) begin
      drive(opv[i], av[i], rv[i]);
      @(posedge clock);
      #1;
      n_cmp++;
      if (obs !== ex[i]) begin
        n_bad++;
        $display("FAIL logic[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_out_pass();
    logic [2:0]  opv[4] = '{3'b100, 3'b011, 3'b100, 3'b011};
    logic [15:0] av[4]  = '{16'h0007, 16'h8000, 16'h8001, 16'h0000};
    logic [15:0] rv[4]  = '{16'h0055, 16'h0009, 16'hFFFF, 16'h0000};
    logic [20:0] ex[4]  = '{{5'b10000, 16'h0007}, {5'b10000, 16'h0009},
                            {5'b10100, 16'h8001}, {5'b11000, 16'h0000}};
    for (int i = 0; i < 4; i++) begin
      drive(opv[i], av[i], rv[i]);
      @(posedge clock);
      #1;
      n_cmp++;
      if (obs !== ex[i]) begin
        n_bad++;
        $display("FAIL out_pass[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  opv[4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    logic [15:0] av[4]  = '{16'd10, 16'd10, 16'hFF00, 16'h1234};
    logic [15:0] rv[4]  = '{16'd5, 16'd5, 16'h0F0F, 16'hBEEF};
    logic [20:0] ex[4]  = '{{5'b10000, 16'd15}, {5'b10010, 16'd5},
                            {5'b10100, 16'hF0FF}, {5'b10000, 16'h1234}};
    for (int i = 0; i < 4; i++) begin
      drive(opv[i], av[i], rv[i]);
      @(posedge clock);
      #1;
      n_cmp++;
      if (obs !== ex[i]) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
    // Idle with unknown operands: everything holds, out_valid drops.
    @(negedge clock);
    in_valid = 1'b0;
    op_sel   = 3'bxxx;
    a        = 16'hxxxx;
    ry       = 16'hxxxx;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (obs !== {5'b00000, 16'h1234}) begin
        n_bad++;
        $display("FAIL hold[%0d]: got %h want %h", i, obs, {5'b00000, 16'h1234});
      end
    end
  endtask

  task automatic test_reset_mid_op();
    drive(3'b000, 16'd4, 16'd4);
    @(posedge clock);
    #1;
    n_cmp++;
    if (obs !== {5'b10000, 16'd8}) begin
      n_bad++;
      $display("FAIL mid_pre: got %h want %h", obs, {5'b10000, 16'd8});
    end
    drive(3'b000, 16'd2, 16'd3);
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 21'd0) begin
      n_bad++;
      $display("FAIL mid_async: got %h want %h", obs, 21'd0);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (obs !== 21'd0) begin
      n_bad++;
      $display("FAIL mid_discard: got %h want %h", obs, 21'd0);
    end
    @(negedge clock);
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (obs !== 21'd0) begin
      n_bad++;
      $display("FAIL mid_idle: got %h want %h", obs, 21'd0);
    end
    drive(3'b000, 16'd2, 16'd3);
    @(posedge clock);
    #1;
    n_cmp++;
    if (obs !== {5'b10000, 16'd5}) begin
      n_bad++;
      $display("FAIL mid_resume: got %h want %h", obs, {5'b10000, 16'd5});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_out_pass();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
